// File: rtl/obi_mem_responder.sv
// obi_mem_responder: OBI slave terminating a crossbar port onto a 1-cycle-read single-port SRAM.
//   clk_i, rst_ni        clock, async active-low reset
//   slave_req_i          OBI request  {req, we, be, addr, wdata}
//   slave_resp_o         OBI response {gnt, rvalid, rdata}
//   mem_*_o / mem_rdata_i SRAM strobe, write enable, byte enables, word address, write/read data
//   oor_o                pulse when an out-of-range request is granted
package obi_pkg;
    typedef struct packed {
        logic        req;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } obi_req_t;
    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
    } obi_resp_t;
endpackage

module obi_mem_responder
    import obi_pkg::*;
#(
    parameter int          MemWords    = 8192,
    parameter int          RespLatency = 1,
    parameter int          GntGap      = 0,
    parameter logic [31:0] ErrData     = 32'hBADCAB1E,
    localparam int         AW          = $clog2(MemWords)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  obi_req_t      slave_req_i,
    output obi_resp_t     slave_resp_o,
    output logic          mem_req_o,
    output logic          mem_we_o,
    output logic [3:0]    mem_be_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [31:0]   mem_wdata_o,
    input  logic [31:0]   mem_rdata_i,
    output logic          oor_o
);
    logic [3:0]             r_gap;
    logic [RespLatency-1:0] r_v;
    logic                   r_we1;
    logic                   r_oor1;
    logic                   w_oor;
    logic                   w_gnt;
    logic                   w_mem;
    logic [31:0]            w_s1_data;
    logic [31:0]            w_out_data;
    logic                   w_unused;

    // byte offset within the word plays no role in a word-wide SRAM
    assign w_unused = ^slave_req_i.addr[1:0];

    assign w_oor = |slave_req_i.addr[31:AW+2];
    // gating with rst_ni keeps gnt low while reset is held
    assign w_gnt = rst_ni && slave_req_i.req && r_gap == 4'd0;
    assign w_mem = w_gnt && !w_oor;

    assign mem_req_o   = w_mem;
    assign mem_we_o    = w_mem && slave_req_i.we;
    assign mem_be_o    = w_mem ? slave_req_i.be : 4'd0;
    assign mem_addr_o  = w_mem ? slave_req_i.addr[AW+1:2] : '0;
    assign mem_wdata_o = w_mem ? slave_req_i.wdata : 32'd0;
    assign oor_o       = w_gnt && w_oor;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_gap  <= 4'd0;
            r_v    <= '0;
            r_we1  <= 1'b0;
            r_oor1 <= 1'b0;
        end else begin
            r_gap  <= w_gnt ? 4'(GntGap) : (r_gap != 4'd0 ? r_gap - 4'd1 : 4'd0);
            r_v    <= (r_v << 1) | RespLatency'(w_gnt);
            r_we1  <= slave_req_i.we;
            r_oor1 <= w_oor;
        end
    end

    // stage 1 data: SRAM read data arrives this cycle, so it is selected combinationally
    assign w_s1_data = r_we1 ? 32'd0 : (r_oor1 ? ErrData : mem_rdata_i);

    if (RespLatency == 1) begin : g_comb
        assign w_out_data = w_s1_data;
    end else begin : g_pipe
        logic [31:0] r_d [2:RespLatency];
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                for (int i = 2; i <= RespLatency; i++) r_d[i] <= 32'd0;
            end else begin
                r_d[2] <= w_s1_data;
                for (int i = 3; i <= RespLatency; i++) r_d[i] <= r_d[i-1];
            end
        end
        assign w_out_data = r_d[RespLatency];
    end

    assign slave_resp_o.gnt    = w_gnt;
    assign slave_resp_o.rvalid = r_v[RespLatency-1];
    assign slave_resp_o.rdata  = r_v[RespLatency-1] ? w_out_data : 32'd0;
endmodule

// File: tb/tb_obi_mem_responder.sv
// tb_obi_mem_responder: directed checks of obi_mem_responder across four parameter sets.
module tb_obi_mem_responder;
    import obi_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    obi_req_t    req [4];
    obi_resp_t   resp [4];
    logic        mreq [4];
    logic        mwe [4];
    logic        oor [4];
    logic [3:0]  mbe [4];
    logic [12:0] maddr [4];
    logic [31:0] mwdata [4];
    int          n_chk = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    // instance 0: defaults, 1: latency 3, 2: gap 2, 3: latency 4
    for (genvar k = 0; k < 4; k++) begin : g_dut
        logic [31:0] m [64];
        logic [31:0] rd;
        initial for (int i = 0; i < 64; i++) m[i] = 32'(32'h11 * (i + 1));
        always @(posedge clk) begin
            if (mreq[k]) begin
                if (mwe[k]) begin
                    for (int b = 0; b < 4; b++)
                        if (mbe[k][b]) m[maddr[k][5:0]][8*b +: 8] <= mwdata[k][8*b +: 8];
                end else begin
                    rd <= m[maddr[k][5:0]];
                end
            end
        end
        obi_mem_responder #(
            .RespLatency(k == 1 ? 3 : (k == 3 ? 4 : 1)),
            .GntGap     (k == 2 ? 2 : 0)
        ) u_dut (
            .clk_i       (clk),
            .rst_ni      (rst_n),
            .slave_req_i (req[k]),
            .slave_resp_o(resp[k]),
            .mem_req_o   (mreq[k]),
            .mem_we_o    (mwe[k]),
            .mem_be_o    (mbe[k]),
            .mem_addr_o  (maddr[k]),
            .mem_wdata_o (mwdata[k]),
            .mem_rdata_i (rd),
            .oor_o       (oor[k])
        );
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic obi_req_t op(input logic we, input logic [3:0] be, input logic [31:0] addr, input logic [31:0] wdata);
        op = '{req: 1'b1, we: we, be: be, addr: addr, wdata: wdata};
    endfunction

    initial begin
        int nm;
        int nv;
        for (int k = 0; k < 4; k++) req[k] = '0;
        #1;
        check("rst_gnt", resp[0].gnt, 0);
        check("rst_rvalid", resp[0].rvalid, 0);
        check("rst_rdata", resp[0].rdata, 0);
        check("rst_mreq", mreq[0], 0);
        check("rst_oor", oor[0], 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        // write then read back word 4
        @(negedge clk); req[0] = op(1, 4'hF, 32'h10, 32'hDEADBEEF); #1;
        check("wr_gnt", resp[0].gnt, 1);
        check("wr_mreq", mreq[0], 1);
        check("wr_mwe", mwe[0], 1);
        check("wr_maddr", maddr[0], 4);
        check("wr_rvalid_early", resp[0].rvalid, 0);
        @(negedge clk); req[0] = op(0, 4'hF, 32'h10, 32'h0); #1;
        check("rd_gnt", resp[0].gnt, 1);
        check("rd_maddr", maddr[0], 4);
        check("rd_mwe", mwe[0], 0);
        check("wr_rvalid", resp[0].rvalid, 1);
        check("wr_rdata", resp[0].rdata, 0);
        @(negedge clk); req[0] = '0; #1;
        check("rd_rvalid", resp[0].rvalid, 1);
        check("rd_rdata", resp[0].rdata, 32'hDEADBEEF);
        @(negedge clk); #1;
        check("rd_idle", resp[0].rvalid, 0);
        // latency 3, three back-to-back reads
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); req[1] = op(0, 4'hF, 32'(4 * i), 32'h0); #1;
            check("l3_gnt", resp[1].gnt, 1);
            check("l3_rvalid_early", resp[1].rvalid, 0);
        end
        @(negedge clk); req[1] = '0; #1;
        check("l3_rv0", resp[1].rvalid, 1);
        check("l3_rd0", resp[1].rdata, 32'h11);
        @(negedge clk); #1;
        check("l3_rv1", resp[1].rvalid, 1);
        check("l3_rd1", resp[1].rdata, 32'h22);
        @(negedge clk); #1;
        check("l3_rv2", resp[1].rvalid, 1);
        check("l3_rd2", resp[1].rdata, 32'h33);
        @(negedge clk); #1;
        check("l3_idle", resp[1].rvalid, 0);
        // grant gap of 2 with request held
        nm = 0;
        nv = 0;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk); req[2] = op(0, 4'hF, 32'h0, 32'h0); #1;
            check("gap_gnt", resp[2].gnt, 32'(i % 3 == 0));
            check("gap_rvalid", resp[2].rvalid, 32'(i % 3 == 1));
            nm += int'(mreq[2]);
            nv += int'(resp[2].rvalid);
        end
        @(negedge clk); req[2] = '0; #1;
        nv += int'(resp[2].rvalid);
        check("gap_mreq_cnt", nm, 3);
        check("gap_rvalid_cnt", nv, 3);
        // out-of-range read then write
        @(negedge clk); req[0] = op(0, 4'hF, 32'h8000, 32'h0); #1;
        check("oor_rd_gnt", resp[0].gnt, 1);
        check("oor_rd_mreq", mreq[0], 0);
        check("oor_rd_pulse", oor[0], 1);
        @(negedge clk); req[0] = op(1, 4'hF, 32'h8000, 32'h1234); #1;
        check("oor_wr_mreq", mreq[0], 0);
        check("oor_wr_pulse", oor[0], 1);
        check("oor_rd_rvalid", resp[0].rvalid, 1);
        check("oor_rd_rdata", resp[0].rdata, 32'hBADCAB1E);
        @(negedge clk); req[0] = '0; #1;
        check("oor_wr_rvalid", resp[0].rvalid, 1);
        check("oor_wr_rdata", resp[0].rdata, 0);
        check("oor_idle", oor[0], 0);
        // byte write
        @(negedge clk); req[0] = op(1, 4'b0010, 32'h20, 32'hA5A5A5A5); #1;
        check("bw_mbe", mbe[0], 4'b0010);
        check("bw_mwe", mwe[0], 1);
        check("bw_maddr", maddr[0], 8);
        @(negedge clk); req[0] = '0; #1;
        check("bw_rvalid", resp[0].rvalid, 1);
        check("bw_rdata", resp[0].rdata, 0);
        // reset with two reads in flight at latency 4
        @(negedge clk); req[3] = op(0, 4'hF, 32'h0, 32'h0); #1;
        check("rs_gnt0", resp[3].gnt, 1);
        @(negedge clk); req[3] = op(0, 4'hF, 32'h4, 32'h0); #1;
        check("rs_gnt1", resp[3].gnt, 1);
        @(negedge clk); rst_n = 1'b0; req[3] = op(0, 4'hF, 32'h8, 32'h0); #1;
        check("rs_gnt_in_rst", resp[3].gnt, 0);
        check("rs_rvalid_in_rst", resp[3].rvalid, 0);
        check("rs_rdata_in_rst", resp[3].rdata, 0);
        check("rs_mreq_in_rst", mreq[3], 0);
        check("rs_mbe_in_rst", mbe[3], 0);
        check("rs_oor_in_rst", oor[3], 0);
        @(negedge clk); rst_n = 1'b1; #1;
        check("rs_gnt_after", resp[3].gnt, 1);
        check("rs_maddr_after", maddr[3], 2);
        @(negedge clk); req[3] = '0; #1;
        check("rs_no_rvalid0", resp[3].rvalid, 0);
        @(negedge clk); #1;
        check("rs_no_rvalid1", resp[3].rvalid, 0);
        @(negedge clk); #1;
        check("rs_no_rvalid2", resp[3].rvalid, 0);
        @(negedge clk); #1;
        check("rs_new_rvalid", resp[3].rvalid, 1);
        check("rs_new_rdata", resp[3].rdata, 32'h33);
        @(negedge clk); #1;
        check("rs_idle", resp[3].rvalid, 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/obi_mem_responder.md
Name: obi_mem_responder

Overview:
- OBI responder (slave end) that terminates one crossbar slave port and drives a single-port, 1-cycle-read SRAM macro.
- Accepts obi_req_t and returns obi_resp_t with a configurable, fixed response latency.
- Supports optional grant wait-states and out-of-range address detection.
- Instantiated behind each memory-bank slave port of the system crossbar.

Parameters:
- MemWords, 8192, number of 32-bit SRAM words (power of two, >=2); AW = $clog2(MemWords).
- RespLatency, 1, cycles from the grant cycle to rvalid (>=1, <=8).
- GntGap, 0, forced idle cycles with gnt low after each accepted request (0..15).
- ErrData, 32'hBADCAB1E, rdata returned for out-of-range reads.

Ports:
- clk_i  input  1  clock.
- rst_ni  input  1  reset.
- slave_req_i  input  obi_req_t  OBI request: req, we, be[3:0], addr[31:0], wdata[31:0].
- slave_resp_o  output  obi_resp_t  OBI response: gnt, rvalid, rdata[31:0].
- mem_req_o  output  1  SRAM access strobe.
- mem_we_o  output  1  SRAM write enable.
- mem_be_o  output  4  SRAM byte enables.
- mem_addr_o  output  AW  SRAM word address.
- mem_wdata_o  output  32  SRAM write data.
- mem_rdata_i  input  32  SRAM read data, valid the cycle after a read strobe.
- oor_o  output  1  one-cycle pulse when an out-of-range request is granted.

Behaviour:
- Interface: one clock (clk_i); reset asynchronous, active-low (rst_ni).
- Reset values:
  - gnt = 0, rvalid = 0, rdata = 0.
  - All mem_* outputs = 0, oor_o = 0.
  - Gap counter and response pipeline cleared.
- Word index = addr[AW+1:2]. A request is out of range when addr[31:AW+2] != 0.
- Grant is combinational: gnt = req && (gap_cnt == 0). A request is accepted in any cycle where req && gnt.
- On acceptance:
  - If in range: mem_req_o = 1 in the same cycle, with mem_we_o = we, mem_be_o = be, mem_addr_o = index, mem_wdata_o = wdata.
  - If out of range: mem_req_o = 0 and oor_o = 1; a write is dropped silently.
  - If not accepted: mem_req_o = 0 and the other mem_* outputs are don't-care.
- Gap counter:
  - Loads GntGap on acceptance and decrements to 0 each cycle.
  - With GntGap = 0, back-to-back acceptance every cycle is allowed.
- Response pipeline: RespLatency stages, each holding {valid, we, oor, data}.
  - Stage 1 is the cycle after acceptance. Its data = mem_rdata_i for an in-range read, ErrData for an out-of-range read, 0 for a write.
  - RespLatency = 1: rvalid/rdata are driven from stage 1. rdata takes mem_rdata_i combinationally.
  - RespLatency > 1: data is registered at the end of stage 1 and shifted through the remaining stages.
  - Output is the last stage: rvalid = stage valid, rdata = stage data when valid, else 0.
- Every accepted transaction, read or write, produces exactly one rvalid pulse, exactly RespLatency cycles after its grant cycle.
- Ordering is strict, since latency is fixed. Up to RespLatency transactions may be outstanding.
- The pipeline cannot stall (OBI has no rready). Acceptance is throttled only by GntGap.
- A request that is held while gnt = 0 must remain stable; address/data changes before the grant are not checked.
- A simultaneous new grant and response retirement in the same cycle is legal, with no bubble.
- Reset asserted mid-operation: in-flight responses are discarded and no rvalid is emitted for them. The first post-reset request is granted with gap_cnt = 0.

Test Plan:
- Defaults; write addr 0x10 wdata 0xDEADBEEF be 4'hF, then read 0x10 -> mem_addr_o = 4 on both grants; read rvalid one cycle after grant with rdata 0xDEADBEEF; write rvalid with rdata 0.
- RespLatency = 3; reads to 0x0, 0x4, 0x8 on 3 consecutive cycles (mem returns 0x11, 0x22, 0x33) -> rvalid in cycles g+3, g+4, g+5 with rdata 0x11, 0x22, 0x33 in order.
- GntGap = 2; req held high for 9 cycles -> gnt high on cycles 0, 3, 6 only; three mem_req_o pulses; three rvalid pulses.
- MemWords = 8192; read 0x0000_8000 -> mem_req_o stays 0, oor_o pulses, rdata 0xBADCAB1E; write to same address -> no mem strobe, rvalid with rdata 0.
- Byte write be 4'b0010 to 0x20 -> mem_be_o = 4'b0010, mem_we_o = 1, mem_addr_o = 8.
- RespLatency = 4; two reads granted, then rst_ni low for 1 cycle at g+2 -> no rvalid observed afterwards; all outputs 0 during reset; next request granted immediately.
